// File: rtl/fetch_if.sv
// fetch_if: fetch-stage bus between the fetch unit, instruction memory, hazard logic and decode.
interface fetch_if #(
  parameter int DBITS = 32,
  parameter int IMEM_ABITS = 12
);
  logic [IMEM_ABITS-1:0] imem_addr;
  logic [DBITS-1:0]      imem_data;
  logic                  stall_in;
  logic                  redirect_valid;
  logic [DBITS-1:0]      redirect_pc;
  logic [DBITS-1:0]      IF_pc;
  logic [3:0]            IF_op;
  logic                  IF_valid;
  logic [DBITS-1:0]      DEC_inst;
  logic [DBITS-1:0]      DEC_pc;
  logic [DBITS-1:0]      DEC_pcplus;
  logic                  DEC_valid;
  logic [15:0]           redir_cnt;
  modport master (
    output imem_addr, IF_pc, IF_op, IF_valid, DEC_inst, DEC_pc, DEC_pcplus, DEC_valid, redir_cnt,
    input  imem_data, stall_in, redirect_valid, redirect_pc
  );
  modport slave (
    input  imem_addr, IF_pc, IF_op, IF_valid, DEC_inst, DEC_pc, DEC_pcplus, DEC_valid, redir_cnt,
    output imem_data, stall_in, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: owns the PC and IF/DEC register; stalls hold, redirects squash the two wrong-path slots.
module fetch_unit #(
  parameter int DBITS = 32,
  parameter int IMEM_ABITS = 12,
  parameter logic [DBITS-1:0] START_PC = 'h40
) (
  input logic clk,
  input logic reset,
  fetch_if.master bus
);
  logic [DBITS-1:0] pc_q, pc_d, fetch_pc_q, fetch_pc_d;
  logic [DBITS-1:0] dec_inst_q, dec_inst_d, dec_pc_q, dec_pc_d;
  logic fetch_valid_q, fetch_valid_d, dec_valid_q, dec_valid_d;
  logic [15:0] redir_cnt_q, redir_cnt_d;
  logic redir, hold, adv;
  always_comb begin
    redir = bus.redirect_valid;
    hold = bus.stall_in && !redir;
    adv = !hold && !redir;
    pc_d = redir ? (bus.redirect_pc & ~DBITS'(3)) : hold ? pc_q : pc_q + DBITS'(4);
    fetch_pc_d = adv ? pc_q : fetch_pc_q;
    fetch_valid_d = redir ? 1'b0 : hold ? fetch_valid_q : 1'b1;
    dec_inst_d = adv ? bus.imem_data : dec_inst_q;
    dec_pc_d = adv ? fetch_pc_q : dec_pc_q;
    dec_valid_d = redir ? 1'b0 : hold ? dec_valid_q : fetch_valid_q;
    redir_cnt_d = redir_cnt_q + 16'(redir);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= START_PC;
      fetch_pc_q <= START_PC;
      fetch_valid_q <= 1'b0;
      dec_inst_q <= '0;
      dec_pc_q <= '0;
      dec_valid_q <= 1'b0;
      redir_cnt_q <= '0;
    end else begin
      pc_q <= pc_d;
      fetch_pc_q <= fetch_pc_d;
      fetch_valid_q <= fetch_valid_d;
      dec_inst_q <= dec_inst_d;
      dec_pc_q <= dec_pc_d;
      dec_valid_q <= dec_valid_d;
      redir_cnt_q <= redir_cnt_d;
    end
  end
  // while stalled, re-read the held instruction so imem_data stays paired with IF_pc
  assign bus.imem_addr = hold ? fetch_pc_q[IMEM_ABITS+1:2] : pc_q[IMEM_ABITS+1:2];
  assign bus.IF_pc = fetch_pc_q;
  assign bus.IF_op = bus.imem_data[DBITS-1:DBITS-4];
  assign bus.IF_valid = fetch_valid_q;
  assign bus.DEC_inst = dec_inst_q;
  assign bus.DEC_pc = dec_pc_q;
  assign bus.DEC_pcplus = dec_pc_q + DBITS'(4);
  assign bus.DEC_valid = dec_valid_q;
  assign bus.redir_cnt = redir_cnt_q;
endmodule
